// File: rtl/fx3_pkg.sv
// Shared constants for the FX3 slave-FIFO responder: socket addresses,
// read-pipeline latency and error-counter width.
package fx3_pkg;

  localparam logic [1:0]  SOCK_RD    = 2'b11;
  localparam logic [1:0]  SOCK_WR    = 2'b00;
  localparam int unsigned RD_LATENCY = 2;
  localparam int unsigned CNT_W      = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/fx3_slave_fifo_resp_sync_fifo.sv
// Single-clock first-word-fall-through FIFO used for both socket buffers.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty   = (level == '0);
    full    = (level == FULL_LVL);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem[rp];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wp] <= din;
  end

endmodule

// File: rtl/fx3_slave_fifo_resp.sv
// FX3-style slave-FIFO responder: a read socket filled by the host stream and
// drained by master reads, and a write socket filled by master writes.
module fx3_slave_fifo_resp
  import fx3_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   SLCS,
  input  logic                   SLOE,
  input  logic                   SLRD,
  input  logic                   SLWR,
  input  logic                   A1,
  input  logic                   A0,
  input  logic [DW-1:0]          dq_in,
  output logic [DW-1:0]          dq_out,
  output logic                   dq_oe,
  output logic                   FLAGA,
  input  logic                   host_in_valid,
  output logic                   host_in_ready,
  input  logic [DW-1:0]          host_in_data,
  output logic                   host_out_valid,
  input  logic                   host_out_ready,
  output logic [DW-1:0]          host_out_data,
  output logic [$clog2(DEPTH):0] rd_level,
  output logic [$clog2(DEPTH):0] wr_level,
  output logic [CNT_W-1:0]       underrun_cnt,
  output logic [CNT_W-1:0]       overrun_cnt,
  output logic                   proto_err
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [1:0]    addr;
  logic          sel_rd, sel_wr, qual, conflict;
  logic          rd_req, wr_req;
  logic          rd_push, rd_pop, wr_push, wr_pop;
  logic          rd_full, rd_empty, wr_full, wr_empty;
  logic          underrun, overrun;
  logic          run;
  logic [DW-1:0] rd_head;
  logic [LW-1:0] rd_lvl_nxt, wr_lvl_nxt;
  logic          flag_nxt;

  logic [RD_LATENCY-1:0] pipe_vld;
  logic [DW-1:0]         pipe_data [RD_LATENCY];

  always_comb begin
    addr     = {A1, A0};
    sel_rd   = (addr == SOCK_RD);
    sel_wr   = (addr == SOCK_WR);
    qual     = !SLCS;
    conflict = qual && !SLRD && !SLWR && (sel_rd || sel_wr);
    rd_req   = qual && sel_rd && !SLOE && !SLRD && SLWR;
    wr_req   = qual && sel_wr && !SLWR && SLRD;

    rd_pop   = rd_req && !rd_empty;
    underrun = rd_req && rd_empty;
    // A full read socket still takes a host word when a master pop frees a slot on the same edge.
    host_in_ready = run && (!rd_full || rd_pop);
    rd_push  = host_in_valid && host_in_ready;

    host_out_valid = !wr_empty;
    wr_pop   = host_out_valid && host_out_ready;
    wr_push  = wr_req && (!wr_full || wr_pop);
    overrun  = wr_req && wr_full && !wr_pop;

    rd_lvl_nxt = rd_level + LW'(rd_push) - LW'(rd_pop);
    wr_lvl_nxt = wr_level + LW'(wr_push) - LW'(wr_pop);
    flag_nxt   = 1'b0;
    if (sel_rd)      flag_nxt = (rd_lvl_nxt != '0);
    else if (sel_wr) flag_nxt = (wr_lvl_nxt != LW'(DEPTH));
  end

  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rd_sock (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_push),
    .pop   (rd_pop),
    .din   (host_in_data),
    .dout  (rd_head),
    .full  (rd_full),
    .empty (rd_empty),
    .level (rd_level)
  );

  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_wr_sock (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_push),
    .pop   (wr_pop),
    .din   (dq_in),
    .dout  (host_out_data),
    .full  (wr_full),
    .empty (wr_empty),
    .level (wr_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      run          <= 1'b0;
      dq_oe        <= 1'b0;
      FLAGA        <= 1'b0;
      dq_out       <= '0;
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
      proto_err    <= 1'b0;
      pipe_vld     <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      run          <= 1'b1;
      dq_oe        <= qual && !SLOE && sel_rd;
      FLAGA        <= flag_nxt;
      underrun_cnt <= sat_inc(underrun_cnt, underrun);
      overrun_cnt  <= sat_inc(overrun_cnt, overrun);
      if (conflict) proto_err <= 1'b1;
      // Popped words ride a fixed-length pipe so bus-side strobe changes cannot cancel them.
      pipe_vld[0]  <= rd_pop;
      pipe_data[0] <= rd_head;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
      if (pipe_vld[RD_LATENCY-1]) dq_out <= pipe_data[RD_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_fx3_slave_fifo_resp.sv
// Self-checking bench for fx3_slave_fifo_resp: directed scenarios plus random
// traffic, checked against a queue-based transaction model.
module tb_fx3_slave_fifo_resp;

  localparam int DW     = 32;
  localparam int DEPTH  = 8;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          SLCS = 1'b1, SLOE = 1'b1, SLRD = 1'b1, SLWR = 1'b1, A1 = 1'b0, A0 = 1'b0;
  logic [DW-1:0] dq_in = '0;
  logic [DW-1:0] dq_out;
  logic          dq_oe, FLAGA;
  logic          host_in_valid = 1'b0;
  logic          host_in_ready;
  logic [DW-1:0] host_in_data = '0;
  logic          host_out_valid;
  logic          host_out_ready = 1'b0;
  logic [DW-1:0] host_out_data;
  logic [LW-1:0] rd_level, wr_level;
  logic [15:0]   underrun_cnt, overrun_cnt;
  logic          proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  fx3_slave_fifo_resp #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .SLCS(SLCS), .SLOE(SLOE), .SLRD(SLRD), .SLWR(SLWR),
    .A1(A1), .A0(A0), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe), .FLAGA(FLAGA),
    .host_in_valid(host_in_valid), .host_in_ready(host_in_ready), .host_in_data(host_in_data),
    .host_out_valid(host_out_valid), .host_out_ready(host_out_ready), .host_out_data(host_out_data),
    .rd_level(rd_level), .wr_level(wr_level), .underrun_cnt(underrun_cnt),
    .overrun_cnt(overrun_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Transaction-level model: socket contents as queues, read words scheduled by edge index.
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] wr_q[$];
  int            due_q[$];
  logic [DW-1:0] dat_q[$];
  logic [DW-1:0] m_dq;
  bit            m_oe, m_flag, m_proto, m_run;
  int            m_under, m_over;
  int            cyc = 0;

  function automatic bit m_rd_req();
    return !SLCS && ({A1, A0} == 2'b11) && !SLOE && !SLRD && SLWR;
  endfunction

  function automatic bit m_wr_req();
    return !SLCS && ({A1, A0} == 2'b00) && !SLWR && SLRD;
  endfunction

  function automatic bit m_both();
    return !SLCS && !SLRD && !SLWR && ({A1, A0} == 2'b11 || {A1, A0} == 2'b00);
  endfunction

  function automatic bit m_hin_ready();
    return m_run && (rd_q.size() < DEPTH || (m_rd_req() && rd_q.size() != 0));
  endfunction

  task automatic step();
    bit rdq, wrq, rpop, wpop, hpush, wpush;
    logic [1:0] a;
    a = {A1, A0};
    if (rst) begin
      rd_q.delete(); wr_q.delete(); due_q.delete(); dat_q.delete();
      m_dq = '0; m_oe = 0; m_flag = 0; m_proto = 0; m_run = 0; m_under = 0; m_over = 0;
    end else begin
      rdq   = m_rd_req();
      wrq   = m_wr_req();
      rpop  = rdq && rd_q.size() != 0;
      wpop  = wr_q.size() != 0 && host_out_ready;
      hpush = host_in_valid && m_hin_ready();
      wpush = wrq && (wr_q.size() < DEPTH || wpop);
      if (rdq && rd_q.size() == 0 && m_under < 65535) m_under++;
      if (wrq && !wpush && m_over < 65535) m_over++;
      if (rpop) begin
        due_q.push_back(cyc + RD_LAT);
        dat_q.push_back(rd_q[0]);
        rd_q.delete(0);
      end
      if (hpush) rd_q.push_back(host_in_data);
      if (wpop) wr_q.delete(0);
      if (wpush) wr_q.push_back(dq_in);
      if (m_both()) m_proto = 1;
      m_oe   = !SLCS && !SLOE && a == 2'b11;
      m_flag = (a == 2'b11) ? (rd_q.size() != 0) : (a == 2'b00) ? (wr_q.size() != DEPTH) : 1'b0;
      m_run  = 1;
      if (due_q.size() != 0 && due_q[0] == cyc) begin
        m_dq = dat_q[0];
        due_q.delete(0);
        dat_q.delete(0);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    SLCS = 1; SLOE = 1; SLRD = 1; SLWR = 1;
  endtask

  task automatic test_reset();
    rst = 1; idle_bus(); host_in_valid = 0; host_out_ready = 0;
    step(); step();
    n_tests++; if (dq_out !== '0)      begin n_fail++; $display("FAIL reset_dq got=%h exp=0", dq_out); end
    n_tests++; if (dq_oe !== 1'b0)     begin n_fail++; $display("FAIL reset_oe got=%b exp=0", dq_oe); end
    n_tests++; if (FLAGA !== 1'b0)     begin n_fail++; $display("FAIL reset_flag got=%b exp=0", FLAGA); end
    n_tests++; if (host_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_hin_ready got=%b exp=0", host_in_ready); end
    n_tests++; if (host_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hout_valid got=%b exp=0", host_out_valid); end
    n_tests++; if (rd_level !== '0 || wr_level !== '0) begin n_fail++; $display("FAIL reset_levels got=%0d/%0d exp=0/0", rd_level, wr_level); end
    n_tests++; if (underrun_cnt !== '0 || overrun_cnt !== '0 || proto_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_errs got=%0d/%0d/%b exp=0/0/0", underrun_cnt, overrun_cnt, proto_err); end
    rst = 0;
    step();
    n_tests++; if (host_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_hin_ready got=%b exp=1", host_in_ready); end
  endtask

  task automatic test_read_burst();
    host_in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      host_in_data = 32'hA0 + i;
      step();
    end
    host_in_valid = 0;
    n_tests++; if (rd_level !== LW'(4)) begin n_fail++; $display("FAIL burst_fill got=%0d exp=4", rd_level); end
    SLCS = 0; SLOE = 0; SLRD = 0; SLWR = 1; A1 = 1; A0 = 1;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) idle_bus();
      step();
      if (k >= 2) begin
        n_tests++; if (dq_out !== DW'(32'hA0 + k - 2)) begin
          n_fail++; $display("FAIL burst_dq k=%0d got=%h exp=%h", k, dq_out, 32'hA0 + k - 2); end
      end
      if (k == 2) begin
        n_tests++; if (FLAGA !== 1'b1) begin n_fail++; $display("FAIL burst_flag_hi got=%b exp=1", FLAGA); end
      end
      if (k == 3) begin
        n_tests++; if (FLAGA !== 1'b0) begin n_fail++; $display("FAIL burst_flag_fall got=%b exp=0", FLAGA); end
        n_tests++; if (dq_oe !== 1'b1) begin n_fail++; $display("FAIL burst_oe got=%b exp=1", dq_oe); end
      end
    end
    n_tests++; if (dq_oe !== 1'b0) begin n_fail++; $display("FAIL burst_oe_off got=%b exp=0", dq_oe); end
  endtask

  task automatic test_underrun();
    SLCS = 0; SLOE = 0; SLRD = 0; SLWR = 1; A1 = 1; A0 = 1;
    repeat (3) step();
    idle_bus();
    step(); step();
    n_tests++; if (underrun_cnt !== 16'd3) begin n_fail++; $display("FAIL underrun_cnt got=%0d exp=3", underrun_cnt); end
    n_tests++; if (dq_out !== 32'hA3)     begin n_fail++; $display("FAIL underrun_dq_hold got=%h exp=a3", dq_out); end
    n_tests++; if (rd_level !== '0)       begin n_fail++; $display("FAIL underrun_level got=%0d exp=0", rd_level); end
    n_tests++; if (underrun_cnt !== 16'(m_under)) begin n_fail++; $display("FAIL underrun_model got=%0d exp=%0d", underrun_cnt, m_under); end
  endtask

  task automatic test_overrun();
    logic [DW-1:0] words[$];
    SLCS = 0; SLWR = 0; SLRD = 1; SLOE = 1; A1 = 0; A0 = 0; host_out_ready = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      dq_in = $urandom;
      words.push_back(dq_in);
      step();
      if (i == DEPTH - 2) begin
        n_tests++; if (FLAGA !== 1'b1) begin n_fail++; $display("FAIL overrun_flag_pre got=%b exp=1", FLAGA); end
      end
      if (i == DEPTH - 1) begin
        n_tests++; if (FLAGA !== 1'b0) begin n_fail++; $display("FAIL overrun_flag_full got=%b exp=0", FLAGA); end
      end
    end
    idle_bus();
    n_tests++; if (wr_level !== LW'(DEPTH)) begin n_fail++; $display("FAIL overrun_level got=%0d exp=%0d", wr_level, DEPTH); end
    n_tests++; if (overrun_cnt !== 16'd2)   begin n_fail++; $display("FAIL overrun_cnt got=%0d exp=2", overrun_cnt); end
    host_out_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_tests++; if (host_out_valid !== 1'b1 || host_out_data !== words[i]) begin
        n_fail++; $display("FAIL overrun_drain i=%0d got=%b/%h exp=1/%h", i, host_out_valid, host_out_data, words[i]); end
      step();
    end
    host_out_ready = 0;
    n_tests++; if (host_out_valid !== 1'b0 || wr_level !== '0) begin
      n_fail++; $display("FAIL overrun_empty got=%b/%0d exp=0/0", host_out_valid, wr_level); end
  endtask

  task automatic test_proto();
    host_in_valid = 1; host_in_data = 32'h5A5A_0001;
    step();
    host_in_valid = 0;
    SLCS = 0; SLOE = 0; SLRD = 0; SLWR = 0; A1 = 1; A0 = 1;
    step();
    idle_bus();
    n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_set got=%b exp=1", proto_err); end
    n_tests++; if (rd_level !== LW'(1) || wr_level !== '0 || underrun_cnt !== 16'd3) begin
      n_fail++; $display("FAIL proto_noop got=%0d/%0d/%0d exp=1/0/3", rd_level, wr_level, underrun_cnt); end
    repeat (3) step();
    n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_sticky got=%b exp=1", proto_err); end
    SLCS = 0; SLOE = 0; SLRD = 0; SLWR = 1; A1 = 0; A0 = 1;
    step();
    n_tests++; if (rd_level !== LW'(1) || underrun_cnt !== 16'd3 || dq_oe !== 1'b0 || FLAGA !== 1'b0) begin
      n_fail++; $display("FAIL addr01_ignored got=%0d/%0d/%b/%b exp=1/3/0/0", rd_level, underrun_cnt, dq_oe, FLAGA); end
    SLRD = 1; SLWR = 0; A1 = 1; A0 = 0; SLOE = 1;
    step();
    idle_bus();
    n_tests++; if (wr_level !== '0 || overrun_cnt !== 16'd2) begin
      n_fail++; $display("FAIL addr10_ignored got=%0d/%0d exp=0/2", wr_level, overrun_cnt); end
  endtask

  task automatic test_reset_midflight();
    host_in_valid = 1;
    repeat (2) begin host_in_data = $urandom; step(); end
    host_in_valid = 0;
    SLCS = 0; SLWR = 0; SLRD = 1; A1 = 0; A0 = 0;
    repeat (5) begin dq_in = $urandom; step(); end
    n_tests++; if (wr_level !== LW'(5)) begin n_fail++; $display("FAIL midrst_wr_level got=%0d exp=5", wr_level); end
    SLWR = 1; SLOE = 0; SLRD = 0; A1 = 1; A0 = 1;
    repeat (2) step();
    rst = 1; idle_bus();
    step();
    rst = 0;
    n_tests++; if (dq_out !== '0 || dq_oe !== 1'b0 || FLAGA !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outs got=%h/%b/%b exp=0/0/0", dq_out, dq_oe, FLAGA); end
    n_tests++; if (wr_level !== '0 || rd_level !== '0 || host_out_valid !== 1'b0 || host_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_socks got=%0d/%0d/%b/%b exp=0/0/0/0", wr_level, rd_level, host_out_valid, host_in_ready); end
    n_tests++; if (proto_err !== 1'b0 || underrun_cnt !== '0 || overrun_cnt !== '0) begin
      n_fail++; $display("FAIL midrst_errs got=%b/%0d/%0d exp=0/0/0", proto_err, underrun_cnt, overrun_cnt); end
    for (int k = 0; k < 2; k++) begin
      step();
      n_tests++; if (dq_out !== '0) begin n_fail++; $display("FAIL midrst_stale k=%0d got=%h exp=0", k, dq_out); end
    end
    n_tests++; if (host_in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_hin_ready got=%b exp=1", host_in_ready); end
  endtask

  task automatic test_full_pushpop();
    logic [DW-1:0] fill[$];
    host_in_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      host_in_data = $urandom; fill.push_back(host_in_data); step();
    end
    host_in_valid = 0;
    #1;
    n_tests++; if (rd_level !== LW'(DEPTH) || host_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_fill got=%0d/%b exp=%0d/0", rd_level, host_in_ready, DEPTH); end
    SLCS = 0; SLOE = 0; SLRD = 0; SLWR = 1; A1 = 1; A0 = 1;
    for (int k = 0; k < DEPTH + 10; k++) begin
      host_in_valid = (k < 6);
      host_in_data  = $urandom;
      if (k == DEPTH + 6) idle_bus();
      #1;
      if (k < 6) begin
        n_tests++; if (host_in_ready !== 1'b1) begin n_fail++; $display("FAIL full_hin_ready k=%0d got=%b exp=1", k, host_in_ready); end
      end
      step();
      if (k < 6) begin
        n_tests++; if (rd_level !== LW'(DEPTH)) begin n_fail++; $display("FAIL full_level k=%0d got=%0d exp=%0d", k, rd_level, DEPTH); end
      end
      if (k == 2) begin
        n_tests++; if (dq_out !== fill[0]) begin n_fail++; $display("FAIL full_first got=%h exp=%h", dq_out, fill[0]); end
      end
      n_tests++; if (dq_out !== m_dq) begin n_fail++; $display("FAIL full_order k=%0d got=%h exp=%h", k, dq_out, m_dq); end
    end
    host_in_valid = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst  = ($urandom_range(0, 79) == 0);
      SLCS = ($urandom_range(0, 3) == 0);
      SLOE = $urandom_range(0, 1);
      SLRD = $urandom_range(0, 1);
      SLWR = ($urandom_range(0, 5) != 0) ? ~SLRD : $urandom_range(0, 1);
      case ($urandom_range(0, 7))
        0, 1, 2: {A1, A0} = 2'b11;
        3, 4, 5: {A1, A0} = 2'b00;
        6:       {A1, A0} = 2'b01;
        default: {A1, A0} = 2'b10;
      endcase
      dq_in          = $urandom;
      host_in_valid  = $urandom_range(0, 1);
      host_in_data   = $urandom;
      host_out_ready = ($urandom_range(0, 2) == 0);
      #1;
      n_tests++; if (host_in_ready !== m_hin_ready()) begin n_fail++; $display("FAIL rnd_hin_ready n=%0d got=%b exp=%b", n, host_in_ready, m_hin_ready()); end
      n_tests++; if (host_out_valid !== (wr_q.size() != 0)) begin n_fail++; $display("FAIL rnd_hout_valid n=%0d got=%b exp=%b", n, host_out_valid, wr_q.size() != 0); end
      if (wr_q.size() != 0) begin
        n_tests++; if (host_out_data !== wr_q[0]) begin n_fail++; $display("FAIL rnd_hout_data n=%0d got=%h exp=%h", n, host_out_data, wr_q[0]); end
      end
      step();
      n_tests++; if (dq_out !== m_dq) begin n_fail++; $display("FAIL rnd_dq n=%0d got=%h exp=%h", n, dq_out, m_dq); end
      n_tests++; if (dq_oe !== m_oe) begin n_fail++; $display("FAIL rnd_oe n=%0d got=%b exp=%b", n, dq_oe, m_oe); end
      n_tests++; if (FLAGA !== m_flag) begin n_fail++; $display("FAIL rnd_flag n=%0d got=%b exp=%b", n, FLAGA, m_flag); end
      n_tests++; if (rd_level !== LW'(rd_q.size()) || wr_level !== LW'(wr_q.size())) begin
        n_fail++; $display("FAIL rnd_levels n=%0d got=%0d/%0d exp=%0d/%0d", n, rd_level, wr_level, rd_q.size(), wr_q.size()); end
      n_tests++; if (underrun_cnt !== 16'(m_under) || overrun_cnt !== 16'(m_over) || proto_err !== m_proto) begin
        n_fail++; $display("FAIL rnd_errs n=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", n, underrun_cnt, overrun_cnt, proto_err, m_under, m_over, m_proto); end
    end
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    test_reset();
    test_read_burst();
    test_underrun();
    test_overrun();
    test_proto();
    test_reset_midflight();
    test_full_pushpop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
